// File: rtl/key_debounce_pkg.sv
// Shared defaults and width helper for the key_debounce input-conditioning block.
package key_debounce_pkg;

    localparam int KEY_DEBOUNCE_CYCLES_DEF = 20000;
    localparam int KEY_LONG_CYCLES_DEF     = 1000000;

    // Counter width for a count that runs 0..cycles-1, never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: 2-flop synchroniser, stability filter, press/release pulses.
// Optional long-press hold counter when LONG_PRESS_EN is defined.
module key_debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF
`ifdef LONG_PRESS_EN
   ,parameter int LONG_CYCLES     = KEY_LONG_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
`ifdef LONG_PRESS_EN
   ,output logic long_press
`endif
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_q, key_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d     = cnt_q;
        key_d     = key_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == key_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            key_d     = s2_q;
            cnt_d     = '0;
            press_d   = s2_q;
            release_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            key_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_in;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_out     = key_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef LONG_PRESS_EN
    localparam int            HW       = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // Hold counter saturates at HOLD_MAX; fired_q limits it to one pulse per press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (!key_q) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end else if (!fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press = long_q;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS raw push-buttons into clean levels plus press/release pulses.
// Define LONG_PRESS_EN to add the long_press output and per-key hold counters.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = KEY_LONG_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
`ifdef LONG_PRESS_EN
   ,output logic [NUM_KEYS-1:0] long_press
`endif
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must both be >= 2");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef LONG_PRESS_EN
           ,.LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[i]),
            .key_out     (key_out[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
`ifdef LONG_PRESS_EN
           ,.long_press  (long_press[i])
`endif
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with NUM_KEYS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=8.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int LC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_out;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
`ifdef LONG_PRESS_EN
    logic [NK-1:0] long_press;
`endif

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
`ifdef LONG_PRESS_EN
       ,.long_press  (long_press)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NK-1:0] key_in;
        int            edges;
        logic [NK-1:0] exp_out;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_rel;
    } vec_t;

    vec_t       vecs_a[$];
    vec_t       vecs_b[$];
    logic [11:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait n rising edges, then sample on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [11:0] exp;
        rst    = v.rst;
        key_in = v.key_in;
        exp_q.push_back({v.exp_out, v.exp_press, v.exp_rel});
        step(v.edges);
        exp = exp_q.pop_front();
        check(name, {20'd0, key_out, key_press, key_release}, {20'd0, exp});
    endtask

`ifdef LONG_PRESS_EN
    task automatic long_run(input string name);
        int cnt = 0;
        int first = -1;
        int others = 0;
        key_in = 4'b0100;
        for (int e = 1; e <= 30; e++) begin
            step(1);
            if (long_press[2]) begin
                cnt++;
                if (first < 0) first = e;
            end
            if ((long_press & 4'b1011) != 4'b0000) others++;
        end
        check({name, "_count"}, cnt, 1);
        check({name, "_edge"}, first, 14);
        check({name, "_other_bits"}, others, 0);
        key_in = 4'b0000;
        step(8);
    endtask
`endif

    initial begin
        // rst, key_in, edges, key_out, key_press, key_release
        vecs_a.push_back('{1'b0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0001, 5, 4'b0000, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0011, 2, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0001, 2, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0011, 2, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0001, 2, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0011, 5, 4'b0001, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0011, 1, 4'b0011, 4'b0010, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1010, 5, 4'b0011, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1010, 1, 4'b1010, 4'b1000, 4'b0001});
        vecs_a.push_back('{1'b0, 4'b0010, 5, 4'b1010, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b1000});
        vecs_a.push_back('{1'b0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0010});
        vecs_a.push_back('{1'b0, 4'b0101, 6, 4'b0101, 4'b0101, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1010, 5, 4'b0101, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1010, 1, 4'b1010, 4'b1010, 4'b0101});
        vecs_a.push_back('{1'b0, 4'b1010, 1, 4'b1010, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1011, 3, 4'b1010, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1010, 8, 4'b1010, 4'b0000, 4'b0000});
        vecs_a.push_back('{1'b0, 4'b1111, 6, 4'b1111, 4'b0101, 4'b0000});

        vecs_b.push_back('{1'b1, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000});
        vecs_b.push_back('{1'b0, 4'b1111, 5, 4'b0000, 4'b0000, 4'b0000});
        vecs_b.push_back('{1'b0, 4'b1111, 1, 4'b1111, 4'b1111, 4'b0000});
        vecs_b.push_back('{1'b0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000});
        vecs_b.push_back('{1'b0, 4'b0000, 6, 4'b0000, 4'b0000, 4'b1111});

        rst    = 1'b1;
        key_in = 4'b0000;
        @(negedge clk);
        step(2);
        check("reset_state", {20'd0, key_out, key_press, key_release}, 32'd0);

        for (int i = 0; i < vecs_a.size(); i++)
            apply(vecs_a[i], $sformatf("vec_a[%0d]", i));

        // Asynchronous reset: outputs clear without any clock edge.
        rst = 1'b1;
        #1;
        check("async_reset", {20'd0, key_out, key_press, key_release}, 32'd0);
`ifdef LONG_PRESS_EN
        check("async_reset_long", {28'd0, long_press}, 32'd0);
`endif
        @(negedge clk);

        for (int i = 0; i < vecs_b.size(); i++)
            apply(vecs_b[i], $sformatf("vec_b[%0d]", i));

`ifdef LONG_PRESS_EN
        long_run("long_first");
        long_run("long_second");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
